lzc_pipe: RTL and testbench

LZC_PIPE -- requirements
Module: lzc_pipe

---
 rtl/lzc_pipe.sv | 159 +++++++++++++++
 tb/tb_lzc_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_pipe.sv
// Two-stage leading/trailing zero/one counter with normalisation and tag pass-through.
// Stage 1 counts inside 16-bit segments; stage 2 merges segments and registers the outputs.
module lzc_pipe #(
    parameter int WIDTH = 64,
    parameter int TAGW  = 4
) (
    input  logic                       CLK,
    input  logic                       RESET_n,
    input  logic                       FLUSH,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           In,
    input  logic [1:0]                 MODE,
    input  logic [TAGW-1:0]            TAG,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH)-1:0]   R,
    output logic                       All_0,
    output logic [WIDTH-1:0]           Norm,
    output logic [TAGW-1:0]            TAG_out,
    output logic                       BUSY
);

    localparam int CW   = $clog2(WIDTH);
    localparam int NSEG = WIDTH / 16;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid may not depend on ready, and a stalled output holds all its fields.

    // Run of target bits from the segment's leading (MSB) or trailing (LSB) end; 16 = whole segment.
    function automatic logic [4:0] seg_count(input logic [15:0] s, input logic tgt, input logic lead);
        logic [15:0] x;
        logic [4:0]  c;
        logic        run;
        for (int i = 0; i < 16; i++) x[i] = lead ? s[i] : s[15-i];
        c   = 5'd0;
        run = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            if (run && (x[i] == tgt)) c = c + 5'd1;
            else                      run = 1'b0;
        end
        return c;
    endfunction

    logic                       s1_valid_q, s1_valid_d;
    logic [NSEG-1:0][3:0]       s1_cnt_q, s1_cnt_d;
    logic [NSEG-1:0]            s1_all_q, s1_all_d;
    logic [WIDTH-1:0]           s1_op_q;
    logic [1:0]                 s1_mode_q;
    logic [TAGW-1:0]            s1_tag_q;

    logic                       ov_q, ov_d;
    logic [CW-1:0]              r_q, r_d;
    logic                       all0_q, all0_d;
    logic [WIDTH-1:0]           norm_q, norm_d;
    logic [TAGW-1:0]            tag_q;

    logic                       s2_accept, accept_in, s1_adv;
    logic [CW-1:0]              acc_lead, acc_trail, acc;
    logic                       done_lead, done_trail;

    assign s2_accept = !ov_q || out_ready;
    assign in_ready  = !FLUSH && (!s1_valid_q || s2_accept);
    assign accept_in = in_valid && in_ready;
    assign s1_adv    = s1_valid_q && s2_accept;

    always_comb begin
        s1_cnt_d = '0;
        s1_all_d = '0;
        for (int s = 0; s < NSEG; s++) begin
            {s1_all_d[s], s1_cnt_d[s]} = seg_count(In[s*16 +: 16], MODE[0], !MODE[1]);
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        ov_d       = ov_q;
        if (FLUSH) begin
            s1_valid_d = 1'b0;
            ov_d       = 1'b0;
        end else begin
            if (accept_in)   s1_valid_d = 1'b1;
            else if (s1_adv) s1_valid_d = 1'b0;
            if (s1_adv)         ov_d = 1'b1;
            else if (out_ready) ov_d = 1'b0;
        end
    end

    // Whole-segment matches add 16 until the first partial segment; overflow only when all match.
    always_comb begin
        acc_lead   = '0;
        done_lead  = 1'b0;
        acc_trail  = '0;
        done_trail = 1'b0;
        for (int j = NSEG - 1; j >= 0; j--) begin
            if (!done_lead) begin
                if (s1_all_q[j]) acc_lead = acc_lead + CW'(16);
                else begin
                    acc_lead  = acc_lead + CW'(s1_cnt_q[j]);
                    done_lead = 1'b1;
                end
            end
        end
        for (int j = 0; j < NSEG; j++) begin
            if (!done_trail) begin
                if (s1_all_q[j]) acc_trail = acc_trail + CW'(16);
                else begin
                    acc_trail  = acc_trail + CW'(s1_cnt_q[j]);
                    done_trail = 1'b1;
                end
            end
        end
        acc    = s1_mode_q[1] ? acc_trail : acc_lead;
        all0_d = &s1_all_q;
        r_d    = all0_d ? '1 : acc;
        norm_d = '0;
        if (!all0_d) norm_d = s1_mode_q[1] ? (s1_op_q >> acc) : (s1_op_q << acc);
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            s1_valid_q <= 1'b0;
            s1_cnt_q   <= '0;
            s1_all_q   <= '0;
            s1_op_q    <= '0;
            s1_mode_q  <= '0;
            s1_tag_q   <= '0;
            ov_q       <= 1'b0;
            r_q        <= '0;
            all0_q     <= 1'b0;
            norm_q     <= '0;
            tag_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            ov_q       <= ov_d;
            if (accept_in) begin
                s1_cnt_q  <= s1_cnt_d;
                s1_all_q  <= s1_all_d;
                s1_op_q   <= In;
                s1_mode_q <= MODE;
                s1_tag_q  <= TAG;
            end
            if (s1_adv && !FLUSH) begin
                r_q    <= r_d;
                all0_q <= all0_d;
                norm_q <= norm_d;
                tag_q  <= s1_tag_q;
            end
        end
    end

    assign out_valid = ov_q;
    assign R         = r_q;
    assign All_0     = all0_q;
    assign Norm      = norm_q;
    assign TAG_out   = tag_q;
    assign BUSY      = s1_valid_q || ov_q;

endmodule

// File: tb/tb_lzc_pipe.sv
// Bench for lzc_pipe: bit-counting model + expected queue checked every output cycle,
// plus directed vectors with literal expectations.
module tb_lzc_pipe;

    localparam int WIDTH = 64;
    localparam int TAGW  = 4;
    localparam int CW    = 6;

    logic              CLK = 1'b0;
    logic              RESET_n, FLUSH, in_valid, in_ready, out_valid, out_ready, All_0, BUSY;
    logic [WIDTH-1:0]  In, Norm;
    logic [1:0]        MODE;
    logic [TAGW-1:0]   TAG, TAG_out;
    logic [CW-1:0]     R;

    lzc_pipe #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .FLUSH(FLUSH),
        .in_valid(in_valid), .in_ready(in_ready), .In(In), .MODE(MODE), .TAG(TAG),
        .out_valid(out_valid), .out_ready(out_ready), .R(R), .All_0(All_0),
        .Norm(Norm), .TAG_out(TAG_out), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [CW-1:0]    r;
        logic             all0;
        logic [WIDTH-1:0] norm;
        logic [TAGW-1:0]  tag;
    } res_t;

    res_t exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reverse trailing-mode operands so the run is always counted from the top bit.
    function automatic res_t model(input logic [WIDTH-1:0] v, input logic [1:0] m, input logic [TAGW-1:0] t);
        res_t             e;
        int               n;
        logic [WIDTH-1:0] x;
        x = m[1] ? {<<{v}} : v;
        n = 0;
        while (n < WIDTH && x[WIDTH-1-n] == m[0]) n++;
        e.tag = t;
        if (n == WIDTH) begin
            e.all0 = 1'b1;
            e.r    = '1;
            e.norm = '0;
        end else begin
            e.all0 = 1'b0;
            e.r    = CW'(n);
            e.norm = m[1] ? (v >> n) : (v << n);
        end
        return e;
    endfunction

    logic        stall;
    logic [75:0] prev;

    always @(negedge CLK) begin
        if (!RESET_n || FLUSH) begin
            exp_q.delete();
            stall = 1'b0;
        end else begin
            if (stall) chk("hold", {out_valid, R, All_0, Norm, TAG_out}, prev);
            if (out_valid) chk("busy_with_out", BUSY, 1);
            if (!BUSY) chk("idle_ready", in_ready, 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                else chk("result", {R, All_0, Norm, TAG_out}, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(model(In, MODE, TAG));
            stall = out_valid && !out_ready;
            prev  = {out_valid, R, All_0, Norm, TAG_out};
        end
    end

    task automatic send(input logic [1:0] m, input logic [WIDTH-1:0] v, input logic [TAGW-1:0] t);
        int n;
        in_valid = 1'b1; MODE = m; In = v; TAG = t; n = 0;
        @(negedge CLK);
        while (!in_ready && n < 50) begin @(negedge CLK); n++; end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1; n = 0;
        @(negedge CLK);
        while (BUSY && n < 50) begin @(negedge CLK); n++; end
        chk("drain_busy", BUSY, 0);
        chk("drain_queue", exp_q.size(), 0);
        @(posedge CLK); #1;
    endtask

    task automatic directed(input string nm, input logic [1:0] m, input logic [WIDTH-1:0] v,
                            input logic [CW-1:0] er, input logic ea, input logic [WIDTH-1:0] en);
        res_t mr;
        mr = model(v, m, 4'hA);
        chk({nm, "_model"}, {mr.r, mr.all0, mr.norm}, {er, ea, en});
        out_ready = 1'b1;
        send(m, v, 4'hA);
        @(negedge CLK);
        chk({nm, "_lat1"}, out_valid, 0);
        @(negedge CLK);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_res"}, {R, All_0, Norm, TAG_out}, {er, ea, en, 4'hA});
        @(posedge CLK); #1;
    endtask

    task automatic set_inputs(input int t);
        logic [WIDTH-1:0] base;
        base = 64'h1;
        MODE = 2'(t);
        TAG  = TAGW'(t);
        In   = (base << (t * 9)) | (base << (t * 13));
    endtask

    logic [WIDTH-1:0] vec [12];
    int   nt, cyc, i, exp_tag;
    logic acc;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_8000_0000_0000, 64'h0000_0000_0001_FFFF,
                64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 64'hFFFF_0000_0000_FFFF,
                64'h0000_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_0000_0000, 64'h0000_FFFF_FFFF_8000};
        RESET_n = 1'b0; FLUSH = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        In = '0; MODE = '0; TAG = '0;
        @(negedge CLK);
        chk("reset_outs", {out_valid, BUSY, R, All_0, Norm, TAG_out}, 0);
        @(posedge CLK); #1;
        RESET_n = 1'b1;
        @(negedge CLK);
        chk("reset_ready", in_ready, 1);
        @(posedge CLK); #1;

        directed("lz47",    2'b00, 64'h0000_0000_0001_0000, 6'd47, 1'b0, 64'h8000_0000_0000_0000);
        directed("lo12",    2'b01, 64'hFFF0_0000_0000_0001, 6'd12, 1'b0, 64'h0000_0000_0000_1000);
        directed("tz8",     2'b10, 64'h0000_0000_0000_0100, 6'd8,  1'b0, 64'h1);
        directed("lz_all",  2'b00, 64'h0,                   6'd63, 1'b1, 64'h0);
        directed("to_all",  2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 1'b1, 64'h0);
        directed("lz_seg",  2'b00, 64'h0000_8000_0000_0000, 6'd16, 1'b0, 64'h8000_0000_0000_0000);
        directed("to17",    2'b11, 64'h0000_0000_0001_FFFF, 6'd17, 1'b0, 64'h0);
        directed("lz0",     2'b00, 64'h8000_0000_0000_0001, 6'd0,  1'b0, 64'h8000_0000_0000_0001);
        drain();

        // Backpressure: five tagged operands with out_ready low for four cycles.
        out_ready = 1'b0; nt = 1; set_inputs(nt); in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            chk("bp_ready", in_ready, (c < 2));
            acc = in_ready;
            @(posedge CLK); #1;
            if (acc) begin nt++; set_inputs(nt); end
        end
        out_ready = 1'b1; exp_tag = 1; cyc = 0;
        while (exp_tag <= 5 && cyc < 20) begin
            @(negedge CLK);
            chk("bp_seq_valid", out_valid, 1);
            chk("bp_seq_tag", TAG_out, exp_tag[TAGW-1:0]);
            exp_tag++; cyc++;
            acc = in_valid && in_ready;
            @(posedge CLK); #1;
            if (acc) begin
                nt++;
                if (nt > 5) in_valid = 1'b0;
                else set_inputs(nt);
            end
        end
        chk("bp_all_out", exp_tag, 6);
        drain();

        // Table stream with a periodic out_ready pattern.
        i = 0; cyc = 0; MODE = 2'd0; In = vec[0]; TAG = 4'd0; in_valid = 1'b1;
        while (i < 12 && cyc < 500) begin
            @(negedge CLK);
            acc = in_ready;
            @(posedge CLK); #1;
            cyc++;
            out_ready = (cyc % 3) != 0;
            if (acc) begin
                i++;
                if (i < 12) begin In = vec[i]; MODE = 2'(i); TAG = TAGW'(i); end
                else in_valid = 1'b0;
            end
        end
        chk("stream_sent", i, 12);
        drain();

        // Flush with two operations in flight and a concurrent input.
        out_ready = 1'b0;
        set_inputs(6); in_valid = 1'b1;
        @(posedge CLK); #1;
        set_inputs(7);
        @(posedge CLK); #1;
        set_inputs(8); FLUSH = 1'b1;
        @(negedge CLK);
        chk("flush_busy_before", BUSY, 1);
        chk("flush_block", in_ready, 0);
        @(posedge CLK); #1;
        FLUSH = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge CLK);
        chk("flush_outs", {out_valid, BUSY}, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("flush_no_out", out_valid, 0);
        end
        @(posedge CLK); #1;

        // Asynchronous reset mid-stream.
        out_ready = 1'b1; MODE = 2'b00; In = 64'h1; TAG = 4'h9; in_valid = 1'b1;
        repeat (3) @(posedge CLK);
        #2;
        chk("pre_reset_busy", BUSY, 1);
        RESET_n = 1'b0;
        #1;
        chk("async_reset_outs", {out_valid, BUSY, R, All_0, Norm, TAG_out}, 0);
        @(posedge CLK); #1;
        in_valid = 1'b0; RESET_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk("post_reset_no_out", {out_valid, BUSY}, 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
